// File: rtl/spi_ram_pkg.sv
// Shared command encoding and word layout for the SPI-fed RAM controller.
package spi_ram_pkg;

  localparam int WORD_W    = 10;
  localparam int CMD_MSB   = 9;
  localparam int CMD_LSB   = 8;
  localparam int PAYLOAD_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Address width needed to index a memory of the given depth (at least 1 bit).
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spram_core.sv
// Plain single-port synchronous RAM: registered read, write on the same edge, no reset.
module spram_core #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Array write and registered read (read-first); kept reset-free so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder in front of a single-port RAM, fed by 10-bit words from an SPI slave.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              seq_err
);

  localparam int AW = addr_bits(MEM_DEPTH);

  logic [1:0]           w_cmd;
  logic [PAYLOAD_W-1:0] w_payload;
  logic [ADDR_SIZE-1:0] w_addr_field;
  logic                 w_do_wr_addr;
  logic                 w_do_wr_data;
  logic                 w_do_rd_addr;
  logic                 w_do_rd_data;
  logic [AW-1:0]        w_mem_addr;
  logic [7:0]           w_rdata;

  logic [AW-1:0]        r_wr_addr;
  logic [AW-1:0]        r_rd_addr;
  logic                 r_wr_addr_set;
  logic                 r_rd_addr_set;
  logic                 r_tx_valid;
  logic                 r_seq_err;
  logic [7:0]           r_tx_hold;

  assign w_cmd        = rx_data[CMD_MSB:CMD_LSB];
  assign w_payload    = rx_data[PAYLOAD_W-1:0];
  assign w_addr_field = rx_data[ADDR_SIZE-1:0];

  assign w_do_wr_addr = rx_valid && (w_cmd == CMD_WR_ADDR);
  assign w_do_wr_data = rx_valid && (w_cmd == CMD_WR_DATA);
  assign w_do_rd_addr = rx_valid && (w_cmd == CMD_RD_ADDR);
  assign w_do_rd_data = rx_valid && (w_cmd == CMD_RD_DATA);

  // The encoding allows only one data access per word, so a simple mux shares the port.
  assign w_mem_addr = w_do_wr_data ? r_wr_addr : r_rd_addr;

  spram_core #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW),
    .DW    (8)
  ) u_core (
    .clk   (clk),
    .we    (w_do_wr_data),
    .addr  (w_mem_addr),
    .wdata (w_payload),
    .rdata (w_rdata)
  );

  // Address registers and their "has been set" flags; upper address bits drop out (wrap).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_wr_addr_set <= 1'b0;
      r_rd_addr_set <= 1'b0;
    end else begin
      if (w_do_wr_addr) begin
        r_wr_addr     <= w_addr_field[AW-1:0];
        r_wr_addr_set <= 1'b1;
      end else if (w_do_wr_data && (AUTO_INC != 0)) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_do_rd_addr) begin
        r_rd_addr     <= w_addr_field[AW-1:0];
        r_rd_addr_set <= 1'b1;
      end else if (w_do_rd_data && (AUTO_INC != 0)) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
    end
  end

  // One-cycle tx_valid / seq_err pulses, plus a copy of the last read byte so tx_data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_seq_err  <= 1'b0;
      r_tx_hold  <= '0;
    end else begin
      r_tx_valid <= w_do_rd_data;
      r_seq_err  <= (w_do_wr_data && !r_wr_addr_set) || (w_do_rd_data && !r_rd_addr_set);
      if (r_tx_valid) begin
        r_tx_hold <= w_rdata;
      end
    end
  end

  // The RAM's registered read is the fresh byte during the pulse; afterwards the held copy.
  assign tx_data  = r_tx_valid ? w_rdata : r_tx_hold;
  assign tx_valid = r_tx_valid;
  assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: one DUT with AUTO_INC=0, one with AUTO_INC=1.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       seq_err;
  logic [9:0] rx_data2;
  logic       rx_valid2;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       seq_err2;

  int n_checks;
  int n_fail;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .seq_err(seq_err)
  );

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut_inc (
    .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .seq_err(seq_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word at a negedge; return at the next negedge, after the consuming posedge.
  task automatic send(input logic [1:0] cmd, input logic [7:0] payload);
    rx_data  = {cmd, payload};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] cmd, input logic [7:0] payload);
    rx_data2  = {cmd, payload};
    rx_valid2 = 1'b1;
    @(negedge clk);
    rx_valid2 = 1'b0;
  endtask

  task automatic idle();
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    send(2'b00, 8'h05);
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_addr_seq: got %b want 0", seq_err); end
    send(2'b01, 8'hA7);
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_data_seq: got %b want 0", seq_err); end
    send(2'b10, 8'h05);
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", tx_valid); end
    send(2'b11, 8'h00);
    n_checks++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_tx_valid: got %b want 1", tx_valid); end
    n_checks++;
    if (tx_data !== 8'hA7) begin n_fail++; $display("FAIL basic_tx_data: got %h want A7", tx_data); end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL basic_rd_seq: got %b want 0", seq_err); end
    idle();
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_end: got %b want 0", tx_valid); end
    n_checks++;
    if (tx_data !== 8'hA7) begin n_fail++; $display("FAIL basic_tx_hold: got %h want A7", tx_data); end
  endtask

  task automatic test_seq_err();
    // Preload mem[0] so the unaddressed read has a known value.
    send(2'b00, 8'h00);
    send(2'b01, 8'h66);
    do_reset();
    send(2'b11, 8'h00);
    n_checks++;
    if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_rd_err: got %b want 1", seq_err); end
    n_checks++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL seq_rd_valid: got %b want 1", tx_valid); end
    n_checks++;
    if (tx_data !== 8'h66) begin n_fail++; $display("FAIL seq_rd_data: got %h want 66", tx_data); end
    idle();
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_rd_err_end: got %b want 0", seq_err); end
    do_reset();
    send(2'b01, 8'h3C);
    n_checks++;
    if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_wr_err: got %b want 1", seq_err); end
    idle();
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_wr_err_end: got %b want 0", seq_err); end
    send(2'b10, 8'h00);
    send(2'b11, 8'h00);
    n_checks++;
    if (tx_data !== 8'h3C) begin n_fail++; $display("FAIL seq_wr_landed: got %h want 3C", tx_data); end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_rd_after_addr: got %b want 0", seq_err); end
    idle();
  endtask

  task automatic test_back_to_back();
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b10, 8'hFF);
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid: got %b want 0", tx_valid); end
    send(2'b11, 8'h00);
    n_checks++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", tx_valid); end
    n_checks++;
    if (tx_data !== 8'h11) begin n_fail++; $display("FAIL b2b_data: got %h want 11", tx_data); end
    // RD_ADDR then RD_DATA on consecutive cycles, then a second RD_DATA straight after.
    send(2'b10, 8'h05);
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid: got %b want 0", tx_valid); end
    send(2'b11, 8'h00);
    n_checks++;
    if (tx_data !== 8'hA7) begin n_fail++; $display("FAIL b2b_newaddr_data: got %h want A7", tx_data); end
    send(2'b11, 8'h00);
    n_checks++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b want 1", tx_valid); end
    idle();
  endtask

  task automatic test_auto_inc();
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h01; exp_rd[1] = 8'h02; exp_rd[2] = 8'h03; exp_rd[3] = 8'h44;
    send2(2'b00, 8'hFE);
    send2(2'b01, 8'h01);
    send2(2'b01, 8'h02);
    send2(2'b01, 8'h03);
    // wr_addr has wrapped to 0x01, so this lands at 0x01.
    send2(2'b01, 8'h44);
    send2(2'b10, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      send2(2'b11, 8'h00);
      n_checks++;
      if (tx_valid2 !== 1'b1) begin n_fail++; $display("FAIL inc_valid_%0d: got %b want 1", i, tx_valid2); end
      n_checks++;
      if (tx_data2 !== exp_rd[i]) begin
        n_fail++; $display("FAIL inc_data_%0d: got %h want %h", i, tx_data2, exp_rd[i]);
      end
    end
    n_checks++;
    if (seq_err2 !== 1'b0) begin n_fail++; $display("FAIL inc_seq: got %b want 0", seq_err2); end
    idle();
  endtask

  task automatic test_reset_midop();
    send(2'b00, 8'h10);
    send(2'b01, 8'h5A);
    send(2'b10, 8'h10);
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", tx_valid); end
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", tx_data); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_late_valid: got %b want 0", tx_valid); end
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    n_checks++;
    if (tx_data !== 8'h5A) begin n_fail++; $display("FAIL midrst_retained: got %h want 5A", tx_data); end
    idle();
  endtask

  task automatic test_idle();
    int bad_valid;
    int bad_err;
    logic [7:0] exp_mem [3];
    logic [7:0] adr [3];
    bad_valid = 0;
    bad_err   = 0;
    rx_valid  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rx_data = 10'($urandom);
      @(negedge clk);
      if (tx_valid !== 1'b0) bad_valid++;
      if (seq_err !== 1'b0) bad_err++;
    end
    n_checks++;
    if (bad_valid != 0) begin n_fail++; $display("FAIL idle_valid: got %0d pulses want 0", bad_valid); end
    n_checks++;
    if (bad_err != 0) begin n_fail++; $display("FAIL idle_seq: got %0d pulses want 0", bad_err); end
    n_checks++;
    if (tx_data !== 8'h5A) begin n_fail++; $display("FAIL idle_tx_hold: got %h want 5A", tx_data); end
    adr[0] = 8'h05; exp_mem[0] = 8'hA7;
    adr[1] = 8'hFF; exp_mem[1] = 8'h11;
    adr[2] = 8'h10; exp_mem[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      send(2'b10, adr[i]);
      send(2'b11, 8'h00);
      n_checks++;
      if (tx_data !== exp_mem[i]) begin
        n_fail++; $display("FAIL idle_mem_%h: got %h want %h", adr[i], tx_data, exp_mem[i]);
      end
    end
    idle();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    rx_data2  = '0;
    rx_valid2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_seq_err();
    test_back_to_back();
    test_auto_inc();
    test_reset_midop();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
